// File: rtl/pwm_shadow_reg_bank_if.sv
// Host-side bus of the PWM shadow register bank: write port, commit/period
// controls, readback port and the active-rank / status outputs.
interface pwm_shadow_reg_bank_if #(
  parameter int BitWidth  = 8,
  parameter int Channels  = 8,
  parameter int AddrWidth = 3
);
  logic                          WR_EN;
  logic [AddrWidth-1:0]          WR_ADDR;
  logic [BitWidth-1:0]           WR_DATA;
  logic                          COMMIT;
  logic                          PERIOD_END;
  logic [AddrWidth-1:0]          RD_ADDR;
  logic                          RD_SEL;
  logic [BitWidth-1:0]           RD_DATA;
  logic [Channels*BitWidth-1:0]  ACTIVE_OUT;
  logic                          PENDING;
  logic                          UPDATED;

  modport master (
    output WR_EN, WR_ADDR, WR_DATA, COMMIT, PERIOD_END, RD_ADDR, RD_SEL,
    input  RD_DATA, ACTIVE_OUT, PENDING, UPDATED
  );

  modport slave (
    input  WR_EN, WR_ADDR, WR_DATA, COMMIT, PERIOD_END, RD_ADDR, RD_SEL,
    output RD_DATA, ACTIVE_OUT, PENDING, UPDATED
  );
endinterface

// File: rtl/pwm_shadow_reg_bank.sv
// Double-buffered per-channel PWM duty/config words. Host writes land in the
// shadow rank; a commit arms a transfer that copies the whole shadow rank into
// the active rank at the next PWM period boundary.
module pwm_shadow_reg_bank #(
  parameter int BitWidth  = 8,
  parameter int Channels  = 8,
  parameter int AddrWidth = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  pwm_shadow_reg_bank_if.slave   bus
);
  typedef enum logic {IDLE, ARMED} state_t;

  localparam logic [AddrWidth:0] CH_LIM = (AddrWidth+1)'(Channels);

  state_t                                 state_q, state_d;
  logic [Channels-1:0][BitWidth-1:0]      shadow_q, shadow_d;
  logic [Channels-1:0][BitWidth-1:0]      active_q, active_d;
  logic [BitWidth-1:0]                    rd_data_q, rd_data_d;
  logic                                   updated_q, updated_d;
  logic                                   xfer;
  logic                                   wr_ok, rd_ok;

  assign wr_ok = bus.WR_EN && ({1'b0, bus.WR_ADDR} < CH_LIM);
  assign rd_ok = {1'b0, bus.RD_ADDR} < CH_LIM;

  // Commit FSM: a commit coinciding with a period end transfers at once,
  // otherwise it arms and waits; further commits while armed are absorbed.
  always_comb begin
    state_d = state_q;
    xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.COMMIT && bus.PERIOD_END) xfer = 1'b1;
        else if (bus.COMMIT)              state_d = ARMED;
      end
      ARMED: begin
        if (bus.PERIOD_END) begin
          xfer    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register ranks: transfer samples the pre-edge shadow, so a same-cycle
  // write reaches shadow only; out-of-range writes/reads are inert.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    rd_data_d = '0;
    updated_d = xfer;
    if (wr_ok) shadow_d[bus.WR_ADDR] = bus.WR_DATA;
    if (xfer)  active_d = shadow_q;
    if (rd_ok) rd_data_d = bus.RD_SEL ? active_q[bus.RD_ADDR] : shadow_q[bus.RD_ADDR];
  end

  // State registers with synchronous reset that overrides everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      active_q  <= '0;
      rd_data_q <= '0;
      updated_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      rd_data_q <= rd_data_d;
      updated_q <= updated_d;
    end
  end

  assign bus.ACTIVE_OUT = active_q;
  assign bus.RD_DATA    = rd_data_q;
  assign bus.PENDING    = (state_q == ARMED);
  assign bus.UPDATED    = updated_q;
endmodule

// File: tb/tb_pwm_shadow_reg_bank.sv
// Bench for pwm_shadow_reg_bank: an 8-channel and a 6-channel instance share
// stimulus; a behavioural model of both is stepped every cycle.
module tb_pwm_shadow_reg_bank;
  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, commit, pe, rd_sel;
  logic [2:0] wr_addr, rd_addr;
  logic [7:0] wr_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_shadow_reg_bank_if #(.BitWidth(8), .Channels(8), .AddrWidth(3)) if8 ();
  pwm_shadow_reg_bank_if #(.BitWidth(8), .Channels(6), .AddrWidth(3)) if6 ();

  assign if8.WR_EN = wr_en;    assign if6.WR_EN = wr_en;
  assign if8.WR_ADDR = wr_addr; assign if6.WR_ADDR = wr_addr;
  assign if8.WR_DATA = wr_data; assign if6.WR_DATA = wr_data;
  assign if8.COMMIT = commit;  assign if6.COMMIT = commit;
  assign if8.PERIOD_END = pe;  assign if6.PERIOD_END = pe;
  assign if8.RD_ADDR = rd_addr; assign if6.RD_ADDR = rd_addr;
  assign if8.RD_SEL = rd_sel;  assign if6.RD_SEL = rd_sel;

  pwm_shadow_reg_bank #(.BitWidth(8), .Channels(8), .AddrWidth(3)) dut8 (
    .CLK(clk), .RST(rst), .bus(if8));
  pwm_shadow_reg_bank #(.BitWidth(8), .Channels(6), .AddrWidth(3)) dut6 (
    .CLK(clk), .RST(rst), .bus(if6));

  // Reference model, index 0 = 8-channel instance, 1 = 6-channel instance.
  int         nch [2] = '{8, 6};
  logic [7:0] m_sh  [2][8];
  logic [7:0] m_act [2][8];
  logic       m_pend [2];
  logic       m_upd  [2];
  logic [7:0] m_rd   [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] m_act_vec(input int d);
    logic [63:0] v = '0;
    for (int k = 0; k < nch[d]; k++) v[k*8 +: 8] = m_act[d][k];
    return v;
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int k = 0; k < 8; k++) begin m_sh[d][k] = '0; m_act[d][k] = '0; end
        m_pend[d] = 1'b0; m_upd[d] = 1'b0; m_rd[d] = '0;
      end else begin
        logic do_xfer;
        m_rd[d] = (int'(rd_addr) < nch[d]) ?
                  (rd_sel ? m_act[d][rd_addr] : m_sh[d][rd_addr]) : 8'h00;
        do_xfer = pe && (m_pend[d] || commit);
        m_pend[d] = m_pend[d] ? !pe : (commit && !pe);
        if (do_xfer) for (int k = 0; k < 8; k++) m_act[d][k] = m_sh[d][k];
        m_upd[d] = do_xfer;
        if (wr_en && int'(wr_addr) < nch[d]) m_sh[d][wr_addr] = wr_data;
      end
    end
  endtask

  task automatic check_all();
    chk("act8", 64'(if8.ACTIVE_OUT), m_act_vec(0));
    chk("rd8",  64'(if8.RD_DATA),    64'(m_rd[0]));
    chk("pend8", 64'(if8.PENDING),   64'(m_pend[0]));
    chk("upd8", 64'(if8.UPDATED),    64'(m_upd[0]));
    chk("act6", 64'(if6.ACTIVE_OUT), m_act_vec(1));
    chk("rd6",  64'(if6.RD_DATA),    64'(m_rd[1]));
    chk("pend6", 64'(if6.PENDING),   64'(m_pend[1]));
    chk("upd6", 64'(if6.UPDATED),    64'(m_upd[1]));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_in();
    rst = 0; wr_en = 0; commit = 0; pe = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] v);
    idle_in(); wr_en = 1; wr_addr = a; wr_data = v; tick(); wr_en = 0;
  endtask

  task automatic rand_traffic(input int cycles, input int rst_mod);
    for (int i = 0; i < cycles; i++) begin
      rst     = ($urandom_range(rst_mod - 1) == 0);
      wr_en   = $urandom_range(1);
      wr_addr = 3'($urandom);
      wr_data = 8'($urandom);
      commit  = ($urandom_range(7) == 0);
      pe      = ($urandom_range(9) == 0);
      rd_addr = 3'($urandom);
      rd_sel  = $urandom_range(1);
      tick();
    end
    idle_in();
  endtask

  initial begin
    rst = 1; wr_en = 0; commit = 0; pe = 0; rd_sel = 0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    tick(); tick();
    chk("rst_act", 64'(if8.ACTIVE_OUT), 64'h0);

    // 1: reset after random traffic
    rand_traffic(200, 1000);
    rst = 1; tick(); rst = 0;
    chk("t1_act", 64'(if8.ACTIVE_OUT), 64'h0);
    chk("t1_rd",  64'(if8.RD_DATA), 64'h0);
    chk("t1_pend", 64'(if8.PENDING), 64'h0);
    chk("t1_upd", 64'(if8.UPDATED), 64'h0);

    // 2: commit waits for period end
    wr(3'd2, 8'hA5); wr(3'd7, 8'h3C);
    idle_in(); commit = 1; tick(); commit = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("t2_pend", 64'(if8.PENDING), 64'h1);
    chk("t2_act0", 64'(if8.ACTIVE_OUT), 64'h0);
    pe = 1; tick(); pe = 0;
    chk("t2_upd", 64'(if8.UPDATED), 64'h1);
    chk("t2_ch2", 64'(if8.ACTIVE_OUT[23:16]), 64'hA5);
    chk("t2_ch7", 64'(if8.ACTIVE_OUT[63:56]), 64'h3C);
    chk("t2_pend0", 64'(if8.PENDING), 64'h0);
    tick();
    chk("t2_upd0", 64'(if8.UPDATED), 64'h0);

    // 3: commit with period end from idle
    wr(3'd0, 8'h11);
    commit = 1; pe = 1; tick(); idle_in();
    chk("t3_ch0", 64'(if8.ACTIVE_OUT[7:0]), 64'h11);
    chk("t3_pend", 64'(if8.PENDING), 64'h0);
    chk("t3_upd", 64'(if8.UPDATED), 64'h1);

    // 4: write while armed included, write in transfer cycle excluded
    commit = 1; tick(); commit = 0;
    wr(3'd1, 8'h22);
    pe = 1; wr_en = 1; wr_addr = 3'd1; wr_data = 8'h99; tick(); idle_in();
    chk("t4_ch1", 64'(if8.ACTIVE_OUT[15:8]), 64'h22);
    rd_addr = 3'd1; rd_sel = 0; tick();
    chk("t4_rd_sh", 64'(if8.RD_DATA), 64'h99);
    rd_sel = 1; tick();
    chk("t4_rd_act", 64'(if8.RD_DATA), 64'h22);

    // 5: out-of-range addresses on the 6-channel instance
    wr(3'd6, 8'hFF); wr(3'd7, 8'hFF);
    rd_addr = 3'd7; rd_sel = 0; tick();
    chk("t5_rd7", 64'(if6.RD_DATA), 64'h0);
    rd_addr = 3'd6; tick();
    chk("t5_rd6", 64'(if6.RD_DATA), 64'h0);
    wr(3'd5, 8'h5A);
    rd_addr = 3'd5; rd_sel = 0; tick();
    chk("t5_rd5", 64'(if6.RD_DATA), 64'h5A);

    // 6: reset drops an armed commit
    rst = 1; tick(); rst = 0;
    wr(3'd3, 8'h77);
    commit = 1; tick(); commit = 0;
    rst = 1; tick(); rst = 0;
    pe = 1; tick(); pe = 0;
    chk("t6_upd", 64'(if8.UPDATED), 64'h0);
    chk("t6_act", 64'(if8.ACTIVE_OUT), 64'h0);
    chk("t6_pend", 64'(if8.PENDING), 64'h0);

    rand_traffic(400, 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
